// File: rtl/dice_sched_pkg.sv
// Shared widths and state encoding for the dice-roll scheduler.
package dice_sched_pkg;

  localparam int SUM_W  = 9;
  localparam int ROLL_W = 5;
  localparam int DIE_W  = 4;
  localparam int CNT_W  = 4;
  localparam int TO_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr upward, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] sel;

  // First requester at or after ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sel = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[sel]) begin
        any      = 1'b1;
        gnt[sel] = 1'b1;
        idx      = sel;
      end
    end
  end

endmodule

// File: rtl/dice_roll_scheduler.sv
// Shares one dice-roll engine among NUM_REQ requesters, summing count rolls.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction; arbitrate and latch winner's die/count
// ST_ISSUE | one-cycle start pulse to the engine
// ST_WAIT  | wait for engine valid; watchdog counting
// ST_DONE  | report sum/error; a count-0 job lingers one extra cycle
module dice_roll_scheduler
  import dice_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [DIE_W*NUM_REQ-1:0] i_dieSelect,
  input  logic [CNT_W*NUM_REQ-1:0] i_count,
  output logic [NUM_REQ-1:0]       o_grant,
  output logic [NUM_REQ-1:0]       o_done,
  output logic [SUM_W-1:0]         o_sum,
  output logic                     o_error,
  output logic                     o_busy,
  output logic                     o_engStart,
  output logic [DIE_W-1:0]         o_engDieSelect,
  input  logic                     i_engValid,
  input  logic [ROLL_W-1:0]        i_engRoll
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sched_state_e state, state_nxt;

  logic [IDX_W-1:0] ptr, ptr_nxt, idx, idx_nxt;
  logic [DIE_W-1:0] die, die_nxt;
  logic [CNT_W-1:0] remaining, rem_nxt;
  logic [SUM_W-1:0] acc, acc_nxt, sum_nxt;
  logic [TO_W-1:0]  tmo_cnt, tmo_nxt;
  logic             err, err_nxt, zero_wait, zero_nxt, error_nxt, emit;
  logic [NUM_REQ-1:0] grant_nxt, done_nxt;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [DIE_W-1:0]   die_sel;
  logic [CNT_W-1:0]   cnt_sel;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req (i_req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign die_sel = i_dieSelect[int'(arb_idx)*DIE_W +: DIE_W];
  assign cnt_sel = i_count[int'(arb_idx)*CNT_W +: CNT_W];

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state, datapath updates and next values of the registered outputs.
  // The watchdog also ticks in ISSUE so that a stall aborts exactly TIMEOUT
  // cycles after the start pulse.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    die_nxt   = die;
    rem_nxt   = remaining;
    acc_nxt   = acc;
    tmo_nxt   = tmo_cnt;
    err_nxt   = err;
    zero_nxt  = zero_wait;
    grant_nxt = '0;
    emit      = 1'b0;
    case (state)
      ST_IDLE: begin
        tmo_nxt = '0;
        if (arb_any) begin
          idx_nxt   = arb_idx;
          die_nxt   = die_sel;
          rem_nxt   = cnt_sel;
          acc_nxt   = '0;
          err_nxt   = 1'b0;
          grant_nxt = arb_gnt;
          if (cnt_sel == '0) begin
            state_nxt = ST_DONE;
            zero_nxt  = 1'b1;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        tmo_nxt   = tmo_cnt + 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_engValid) begin
          acc_nxt = acc + SUM_W'(i_engRoll);
          rem_nxt = remaining - 1'b1;
          tmo_nxt = '0;
          if (remaining == CNT_W'(1)) begin
            state_nxt = ST_DONE;
            emit      = 1'b1;
          end else begin
            state_nxt = ST_ISSUE;
          end
        end else if ((tmo_cnt + 1'b1) == TO_W'(TIMEOUT)) begin
          err_nxt   = 1'b1;
          state_nxt = ST_DONE;
          emit      = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (zero_wait) begin
          zero_nxt = 1'b0;
          emit     = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
          ptr_nxt   = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    done_nxt  = '0;
    sum_nxt   = o_sum;
    error_nxt = o_error;
    if (emit) begin
      done_nxt[idx] = 1'b1;
      sum_nxt       = acc_nxt;
      error_nxt     = err_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr            <= '0;
      idx            <= '0;
      die            <= '0;
      remaining      <= '0;
      acc            <= '0;
      tmo_cnt        <= '0;
      err            <= 1'b0;
      zero_wait      <= 1'b0;
      o_grant        <= '0;
      o_done         <= '0;
      o_sum          <= '0;
      o_error        <= 1'b0;
      o_busy         <= 1'b0;
      o_engStart     <= 1'b0;
      o_engDieSelect <= '0;
    end else begin
      ptr            <= ptr_nxt;
      idx            <= idx_nxt;
      die            <= die_nxt;
      remaining      <= rem_nxt;
      acc            <= acc_nxt;
      tmo_cnt        <= tmo_nxt;
      err            <= err_nxt;
      zero_wait      <= zero_nxt;
      o_grant        <= grant_nxt;
      o_done         <= done_nxt;
      o_sum          <= sum_nxt;
      o_error        <= error_nxt;
      o_busy         <= (state_nxt != ST_IDLE);
      o_engStart     <= (state_nxt == ST_ISSUE);
      o_engDieSelect <= die_nxt;
    end
  end

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Directed bench for dice_roll_scheduler with a small engine responder.
module tb_dice_roll_scheduler;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  i_req = '0;
  logic [15:0] i_dieSelect = '0;
  logic [15:0] i_count = '0;
  logic        i_engValid = 1'b0;
  logic [4:0]  i_engRoll = '0;
  logic [3:0]  o_grant, o_done;
  logic [8:0]  o_sum;
  logic        o_error, o_busy, o_engStart;
  logic [3:0]  o_engDieSelect;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_start = 0;
  int start_cyc = 0;
  logic pend = 1'b0;
  logic late_pulse = 1'b0;
  logic die_chk_en = 1'b0;
  logic [3:0] exp_die = '0;
  int roll_q[$];

  dice_roll_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req          (i_req),
    .i_dieSelect    (i_dieSelect),
    .i_count        (i_count),
    .o_grant        (o_grant),
    .o_done         (o_done),
    .o_sum          (o_sum),
    .o_error        (o_error),
    .o_busy         (o_busy),
    .o_engStart     (o_engStart),
    .o_engDieSelect (o_engDieSelect),
    .i_engValid     (i_engValid),
    .i_engRoll      (i_engRoll)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++)
      if (v[i]) r = (r == -1) ? i : -2;
    return r;
  endfunction

  task automatic wait_grant(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (o_grant == '0 && lat < 50);
    if (o_grant == '0) chk_val({tag, "_grant_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string tag, input int max, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (o_done == '0 && lat < max);
    if (o_done == '0) chk_val({tag, "_done_timeout"}, 0, 1);
  endtask

  // Engine model: answers a start one cycle later (while the DUT is in WAIT)
  // with the next queued roll; an empty queue models a stalled engine.
  initial begin
    forever begin
      @(negedge clk);
      i_engValid = 1'b0;
      if (late_pulse) begin
        i_engValid = 1'b1;
        i_engRoll  = 5'd7;
        late_pulse = 1'b0;
      end else if (pend) begin
        pend = 1'b0;
        if (roll_q.size() > 0) begin
          i_engValid = 1'b1;
          i_engRoll  = 5'(roll_q.pop_front());
        end
      end
      if (o_engStart) begin
        n_start++;
        start_cyc = cyc;
        pend = 1'b1;
        if (die_chk_en) chk_val("die_stable", int'(o_engDieSelect), int'(exp_die));
      end
    end
  end

  initial begin
    int lat, s0, gi, bad;
    int rr_exp[5] = '{0, 1, 2, 3, 0};

    // reset state
    repeat (3) @(negedge clk);
    chk_val("rst_busy", int'(o_busy), 0);
    chk_val("rst_grant", int'(o_grant), 0);
    chk_val("rst_done", int'(o_done), 0);
    chk_val("rst_sum", int'(o_sum), 0);
    chk_val("rst_start", int'(o_engStart), 0);
    reset = 1'b0;
    @(negedge clk);

    // single roll: requester 0, die 6, roll 4
    roll_q = '{4};
    s0 = n_start;
    i_dieSelect[3:0] = 4'd6;
    i_count[3:0] = 4'd1;
    i_req[0] = 1'b1;
    wait_grant("t1", lat);
    chk_val("t1_grant", int'(o_grant), 4'b0001);
    chk_val("t1_grant_lat", lat, 1);
    chk_val("t1_start_with_grant", int'(o_engStart), 1);
    chk_val("t1_busy", int'(o_busy), 1);
    chk_val("t1_die", int'(o_engDieSelect), 6);
    i_req[0] = 1'b0;
    wait_done("t1", 20, lat);
    chk_val("t1_done", int'(o_done), 4'b0001);
    chk_val("t1_sum", int'(o_sum), 4);
    chk_val("t1_err", int'(o_error), 0);
    chk_val("t1_starts", n_start - s0, 1);

    // multi-roll: requester 2, die 8, rolls 5,1,6
    roll_q = '{5, 1, 6};
    s0 = n_start;
    i_dieSelect[11:8] = 4'd8;
    i_count[11:8] = 4'd3;
    exp_die = 4'd8;
    die_chk_en = 1'b1;
    i_req[2] = 1'b1;
    wait_grant("t2", lat);
    chk_val("t2_grant", int'(o_grant), 4'b0100);
    i_req[2] = 1'b0;
    wait_done("t2", 50, lat);
    die_chk_en = 1'b0;
    chk_val("t2_done", int'(o_done), 4'b0100);
    chk_val("t2_sum", int'(o_sum), 12);
    chk_val("t2_starts", n_start - s0, 3);
    chk_val("t2_die_at_done", int'(o_engDieSelect), 8);

    // count zero: requester 3
    s0 = n_start;
    i_dieSelect[15:12] = 4'd3;
    i_count[15:12] = 4'd0;
    i_req[3] = 1'b1;
    wait_grant("t3", lat);
    chk_val("t3_grant", int'(o_grant), 4'b1000);
    chk_val("t3_no_early_done", int'(o_done), 0);
    i_req[3] = 1'b0;
    @(negedge clk);
    chk_val("t3_done_next", int'(o_done), 4'b1000);
    chk_val("t3_sum", int'(o_sum), 0);
    chk_val("t3_err", int'(o_error), 0);
    chk_val("t3_starts", n_start - s0, 0);

    // round robin: everyone asks, re-requests after done
    i_count = 16'h1111;
    i_dieSelect = 16'h4321;
    roll_q = '{1, 2, 3, 4, 5};
    i_req = 4'hf;
    for (int g = 0; g < 5; g++) begin
      wait_grant("rr", lat);
      gi = oh_idx(o_grant);
      chk_val("rr_order", gi, rr_exp[g]);
      if (g == 4) i_req = '0;
      else if (gi >= 0) i_req[gi] = 1'b0;
      wait_done("rr", 20, lat);
      chk_val("rr_sum", int'(o_sum), g + 1);
      if (g < 4 && gi >= 0) i_req[gi] = 1'b1;
    end

    // timeout: requester 1, count 2, first roll 9 then engine stalls
    roll_q = '{9};
    s0 = n_start;
    i_count[7:4] = 4'd2;
    i_dieSelect[7:4] = 4'd2;
    i_req[1] = 1'b1;
    wait_grant("t5", lat);
    chk_val("t5_grant", int'(o_grant), 4'b0010);
    i_req[1] = 1'b0;
    wait_done("t5", TIMEOUT + 100, lat);
    chk_val("t5_done", int'(o_done), 4'b0010);
    chk_val("t5_err", int'(o_error), 1);
    chk_val("t5_partial_sum", int'(o_sum), 9);
    chk_val("t5_abort_delay", cyc - start_cyc, TIMEOUT);
    chk_val("t5_starts", n_start - s0, 2);
    late_pulse = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_busy || o_done != '0 || o_engStart) bad++;
    end
    chk_val("t5_late_valid_ignored", bad, 0);
    chk_val("t5_sum_held", int'(o_sum), 9);

    // reset during second of three rolls
    roll_q = '{3};
    s0 = n_start;
    i_count[7:4] = 4'd3;
    i_dieSelect[7:4] = 4'd5;
    i_req[1] = 1'b1;
    wait_grant("t6", lat);
    i_req[1] = 1'b0;
    lat = 0;
    while (n_start - s0 < 2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk_val("t6_second_start", n_start - s0, 2);
    repeat (3) @(negedge clk);
    chk_val("t6_busy_in_wait", int'(o_busy), 1);
    reset = 1'b1;
    #2;
    chk_val("t6_rst_busy", int'(o_busy), 0);
    chk_val("t6_rst_sum", int'(o_sum), 0);
    chk_val("t6_rst_err", int'(o_error), 0);
    chk_val("t6_rst_die", int'(o_engDieSelect), 0);
    chk_val("t6_rst_done", int'(o_done), 0);
    pend = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (o_busy || o_done != '0) bad++;
    end
    chk_val("t6_dropped", bad, 0);
    i_count[7:4] = 4'd1;
    i_count[15:12] = 4'd1;
    roll_q = '{2};
    i_req = 4'b1010;
    wait_grant("t6b", lat);
    chk_val("t6b_grant_ptr0", int'(o_grant), 4'b0010);
    chk_val("t6b_die", int'(o_engDieSelect), 5);
    i_req = '0;
    wait_done("t6b", 20, lat);
    chk_val("t6b_done", int'(o_done), 4'b0010);
    chk_val("t6b_sum", int'(o_sum), 2);
    chk_val("t6b_err", int'(o_error), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
